// File: rtl/imem_fetch_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_fetch_responder_if : fetch address / instruction response handshake bundle
// Revision 1.0
// ----------------------------------------------------------------------------
interface imem_fetch_responder_if;
  logic        addr_valid;
  logic [31:0] addr;
  logic        addr_ready;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        misaligned;
  logic        out_of_range;

  modport master (
    output addr_valid, addr, instr_ready,
    input  addr_ready, instr_valid, instr, misaligned, out_of_range
  );

  modport slave (
    input  addr_valid, addr, instr_ready,
    output addr_ready, instr_valid, instr, misaligned, out_of_range
  );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_fetch_responder : instruction memory answering PC fetches after wait states
// Revision 1.0
// ----------------------------------------------------------------------------
module imem_fetch_responder #(
  parameter int          DEPTH       = 64,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] HALT_ADDR   = 32'h0000_007C,
  parameter string       INIT_FILE   = ""
) (
  input  wire                    clk,
  input  wire                    reset,
  imem_fetch_responder_if.slave  fetch,
  output logic                   halted,
  output logic [15:0]            fetch_count,
  input  wire                    wr_en,
  input  wire [31:0]             wr_addr,
  input  wire [31:0]             wr_data
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_READ = 3'd2,
    S_RESP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] lat_addr;
  logic [31:0] rd_word;
  logic        rd_phase;
  logic        ready_q;
  logic        valid_q;
  logic        mis_q;
  logic        oor_q;
  logic [31:0] instr_q;

  logic        lat_mis;
  logic        lat_oor;
  logic        wr_hit;
  logic        unused_wr_lsb;

  assign lat_mis       = lat_addr[1:0] != 2'b00;
  assign lat_oor       = lat_addr[31:2] >= DEPTH_W;
  assign wr_hit        = wr_addr[31:2] < DEPTH_W;
  assign unused_wr_lsb = ^wr_addr[1:0];

  assign fetch.addr_ready   = ready_q;
  assign fetch.instr_valid  = valid_q;
  assign fetch.instr        = instr_q;
  assign fetch.misaligned   = mis_q;
  assign fetch.out_of_range = oor_q;

  // Memory contents survive reset, so the write port has no reset branch.
  always_ff @(posedge clk) begin
    if (wr_en && wr_hit) begin
      mem[wr_addr[AW+1:2]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      wait_cnt    <= 4'd0;
      lat_addr    <= 32'd0;
      rd_word     <= 32'd0;
      rd_phase    <= 1'b0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      mis_q       <= 1'b0;
      oor_q       <= 1'b0;
      instr_q     <= 32'd0;
      halted      <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch.addr_valid && ready_q) begin
            lat_addr <= fetch.addr;
            wait_cnt <= 4'(WAIT_STATES);
            rd_phase <= 1'b0;
            ready_q  <= 1'b0;
            state    <= (WAIT_STATES == 0) ? S_READ : S_WAIT;
          end else begin
            ready_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= S_READ;
          end
        end
        // Array read is registered first; a write on that same edge is not seen.
        S_READ: begin
          if (!rd_phase) begin
            rd_word  <= mem[lat_addr[AW+1:2]];
            rd_phase <= 1'b1;
          end else begin
            instr_q  <= (lat_mis || lat_oor) ? 32'd0 : rd_word;
            mis_q    <= lat_mis;
            oor_q    <= lat_oor;
            valid_q  <= 1'b1;
            rd_phase <= 1'b0;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (fetch.instr_ready) begin
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            oor_q   <= 1'b0;
            instr_q <= 32'd0;
            if (fetch_count != 16'hFFFF) begin
              fetch_count <= fetch_count + 16'd1;
            end
            if (lat_addr == HALT_ADDR) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              ready_q <= 1'b1;
              state   <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          ready_q <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_imem_fetch_responder : three responders (1, 0, 5 wait states) against a word-array model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_imem_fetch_responder;

  localparam int          N    = 3;
  localparam logic [31:0] HALT = 32'h0000_007C;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  logic        av  [N];
  logic [31:0] aa  [N];
  logic        ir  [N];
  logic        ar  [N];
  logic        iv  [N];
  logic [31:0] ins [N];
  logic        mis [N];
  logic        oor [N];
  logic        hlt [N];
  logic [15:0] fc  [N];

  logic [31:0] mm [64];
  int          mcount [N];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    imem_fetch_responder_if fi ();
    assign fi.addr_valid  = av[g];
    assign fi.addr        = aa[g];
    assign fi.instr_ready = ir[g];
    assign ar[g]  = fi.addr_ready;
    assign iv[g]  = fi.instr_valid;
    assign ins[g] = fi.instr;
    assign mis[g] = fi.misaligned;
    assign oor[g] = fi.out_of_range;

    imem_fetch_responder #(
      .DEPTH       (64),
      .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 5)),
      .HALT_ADDR   (HALT),
      .INIT_FILE   ("")
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .fetch       (fi),
      .halted      (hlt[g]),
      .fetch_count (fc[g]),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data)
    );
  end

  function automatic int ws_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 5);
  endfunction

  function automatic logic [31:0] expect_word(logic [31:0] a);
    if (a[1:0] != 2'b00 || a[31:2] >= 30'd64) return 32'd0;
    return mm[a[7:2]];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a[31:2] < 30'd64) mm[a[7:2]] = d;
  endtask

  task automatic clear_counts;
    for (int k = 0; k < N; k++) mcount[k] = 0;
  endtask

  // late_wr puts a write on the same edge that presents the response.
  task automatic fetch(input int k, input logic [31:0] a, input int hold,
                       input bit late_wr, input logic [31:0] wa, input logic [31:0] wd);
    logic [31:0] exp_w;
    int          lat;
    int          guard;
    exp_w = expect_word(a);
    guard = 0;
    while (!ar[k] && guard < 20) begin tick(); guard++; end
    check("addr_ready_idle", 32'(ar[k]), 32'd1);
    av[k] = 1'b1; aa[k] = a;
    tick();
    av[k] = 1'b0; aa[k] = $urandom;
    lat = 0;
    while (!iv[k] && lat < 40) begin
      if (late_wr && lat == ws_of(k) + 1) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end
      tick();
      wr_en = 1'b0;
      lat++;
    end
    if (late_wr && wa[31:2] < 30'd64) mm[wa[7:2]] = wd;
    check("latency", 32'(lat), 32'(2 + ws_of(k)));
    for (int h = 0; h <= hold; h++) begin
      check("instr", ins[k], exp_w);
      check("misaligned", 32'(mis[k]), 32'(a[1:0] != 2'b00));
      check("out_of_range", 32'(oor[k]), 32'(a[31:2] >= 30'd64));
      check("instr_valid", 32'(iv[k]), 32'd1);
      check("addr_ready_busy", 32'(ar[k]), 32'd0);
      if (h < hold) tick();
    end
    ir[k] = 1'b1;
    tick();
    ir[k] = 1'b0;
    if (mcount[k] < 65535) mcount[k]++;
    check("valid_clear", 32'(iv[k]), 32'd0);
    check("fetch_count", 32'(fc[k]), 32'(mcount[k]));
    check("halted", 32'(hlt[k]), 32'(a == HALT));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    int          k;
    int          mode;
    int          seen;

    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < N; i++) begin av[i] = 1'b0; aa[i] = '0; ir[i] = 1'b0; end
    clear_counts();
    repeat (2) tick();
    for (int i = 0; i < N; i++) begin
      check("rst_addr_ready", 32'(ar[i]), 32'd0);
      check("rst_instr_valid", 32'(iv[i]), 32'd0);
      check("rst_instr", ins[i], 32'd0);
      check("rst_flags", {30'd0, mis[i], oor[i]}, 32'd0);
      check("rst_halted", 32'(hlt[i]), 32'd0);
      check("rst_count", 32'(fc[i]), 32'd0);
    end
    reset = 1'b1;
    tick();

    for (int i = 0; i < 64; i++) do_write(32'(i * 4), $urandom);

    // Directed scenarios on the one-wait-state responder.
    do_write(32'h0, 32'h2008_0005);
    fetch(0, 32'h0, 4, 1'b0, '0, '0);
    fetch(0, 32'h6, 0, 1'b0, '0, '0);
    fetch(0, 32'h100, 0, 1'b0, '0, '0);
    do_write(32'h8, 32'h1111_1111);
    fetch(0, 32'h8, 0, 1'b1, 32'h8, 32'hAAAA_5555);
    check("late_write_old", ins[0] | 32'h0, 32'h0);
    fetch(0, 32'h8, 0, 1'b0, '0, '0);
    do_write(32'h100, 32'hBAD0_BAD0);
    fetch(1, 32'h0, 1, 1'b0, '0, '0);

    // Reset in the middle of the five-wait-state responder's WAIT.
    while (!ar[2]) tick();
    av[2] = 1'b1; aa[2] = 32'h10;
    tick();
    av[2] = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #2;
    clear_counts();
    check("abort_valid", 32'(iv[2]), 32'd0);
    check("abort_ready", 32'(ar[2]), 32'd0);
    check("abort_count", 32'(fc[2]), 32'd0);
    tick();
    reset = 1'b1;
    seen = 0;
    repeat (10) begin tick(); if (iv[2]) seen++; end
    check("abort_no_resp", 32'(seen), 32'd0);
    fetch(2, 32'h10, 1, 1'b0, '0, '0);

    for (int n = 0; n < 40; n++) begin
      k    = $urandom_range(0, N - 1);
      mode = $urandom_range(0, 5);
      if ($urandom_range(0, 2) == 0) begin
        w = $urandom;
        if ($urandom_range(0, 1) == 0) do_write({24'd0, 6'($urandom_range(0, 63)), 2'b00}, w);
        else do_write(32'h100 + 32'($urandom_range(0, 4095)), w);
      end
      if (mode <= 3)      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      else if (mode == 4) a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else                a = $urandom | 32'h0000_0100;
      if (a == HALT) a = 32'h0;
      fetch(k, a, $urandom_range(0, 3), 1'b0, '0, '0);
    end

    // Halt entry, ignored fetches while halted, exit by reset.
    do_write(HALT, 32'hDEAD_BEEF);
    fetch(0, HALT, 1, 1'b0, '0, '0);
    check("halt_ready", 32'(ar[0]), 32'd0);
    av[0] = 1'b1; aa[0] = 32'h0;
    seen = 0;
    repeat (6) begin tick(); if (iv[0] || ar[0]) seen++; end
    av[0] = 1'b0;
    check("halt_ignores", 32'(seen), 32'd0);
    check("halt_count", 32'(fc[0]), 32'(mcount[0]));
    check("halt_held", 32'(hlt[0]), 32'd1);
    reset = 1'b0;
    #2;
    clear_counts();
    check("halt_reset", 32'(hlt[0]), 32'd0);
    tick();
    reset = 1'b1;
    fetch(0, 32'h0, 0, 1'b0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
